// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Multi-mode VGA test-pattern generator. Maps the current pixel coordinate
//   to a registered RGB565 colour: vertical bars, horizontal bars,
//   checkerboard or horizontally scrolling bars. Mode requests are held
//   pending and applied only on the frame boundary (last active pixel) so a
//   frame is never torn.
//
//   Optional build macro: VGA_PAT_BORDER_EN -- when defined, a 1-pixel white
//   border is drawn around the active area on top of the mode colour.
//
// Ports:
//   vga_clk    in   1   pixel clock
//   sys_rst_n  in   1   asynchronous active-low reset
//   pix_x      in  10   current pixel X coordinate
//   pix_y      in  10   current pixel Y coordinate
//   mode_req   in   2   requested mode (0 vbars, 1 hbars, 2 checker, 3 scroll)
//   mode_vld   in   1   single-cycle strobe qualifying mode_req
//   pix_data   out 16   RGB565 colour, one cycle after pix_x/pix_y
//   mode_cur   out  2   mode currently applied
//   frame_cnt  out  8   completed-frame counter (wraps)
module vga_pattern_gen #(
  parameter int H_VALID     = 640,
  parameter int V_VALID     = 480,
  parameter int BAR_NUM     = 8,
  parameter int CHECK_SHIFT = 5,
  parameter int SCROLL_STEP = 4
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [1:0]  mode_req,
  input  logic        mode_vld,
  output logic [15:0] pix_data,
  output logic [1:0]  mode_cur,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    MODE_VBAR   = 2'd0,
    MODE_HBAR   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_e;

  localparam int unsigned BAR_W  = H_VALID / BAR_NUM;
  localparam int unsigned BAR_H  = V_VALID / BAR_NUM;
  localparam int unsigned BAR_N  = BAR_NUM;
  localparam logic [10:0] H_W    = 11'(H_VALID);
  localparam logic [10:0] V_W    = 11'(V_VALID);
  localparam logic [10:0] STEP_W = 11'(SCROLL_STEP);
  localparam logic [9:0]  H_LAST = 10'(H_VALID - 1);
  localparam logic [9:0]  V_LAST = 10'(V_VALID - 1);

  mode_e       mode_q;
  mode_e       pending;
  logic        pend_flag;
  logic [9:0]  offset;

  logic        active;
  logic        fb;
  logic [10:0] ex;
  logic [10:0] off_sum;
  logic [9:0]  off_nxt;
  logic [15:0] color_d;

  // Bar index by counting how many bar thresholds the coordinate has passed;
  // the 3-bit accumulator wraps, giving the palette index modulo 8 directly.
  function automatic logic [2:0] bar_sel(input logic [10:0] c, input int unsigned w);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned k = 1; k < BAR_N; k++) begin
      if (c >= 11'(k * w)) idx = idx + 3'd1;
    end
    return idx;
  endfunction

  function automatic logic [15:0] palette(input logic [2:0] i);
    logic [15:0] c;
    case (i)
      3'd0:    c = 16'hF800;
      3'd1:    c = 16'hFC00;
      3'd2:    c = 16'hFFE0;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'h07FF;
      3'd5:    c = 16'h001F;
      3'd6:    c = 16'hF81F;
      default: c = 16'hFFFF;
    endcase
    return c;
  endfunction

  always_comb begin
    active = ({1'b0, pix_x} < H_W) && ({1'b0, pix_y} < V_W);
    fb     = (pix_x == H_LAST) && (pix_y == V_LAST);

    // Scrolled X: both operands are below H_VALID, so one subtraction wraps.
    ex = {1'b0, pix_x} + {1'b0, offset};
    if (ex >= H_W) ex = ex - H_W;

    off_sum = {1'b0, offset} + STEP_W;
    if (off_sum >= H_W) off_nxt = 10'(off_sum - H_W);
    else                off_nxt = off_sum[9:0];

    color_d = '0;
    if (active) begin
      case (mode_q)
        MODE_VBAR:   color_d = palette(bar_sel({1'b0, pix_x}, BAR_W));
        MODE_HBAR:   color_d = palette(bar_sel({1'b0, pix_y}, BAR_H));
        MODE_CHECK:  color_d = (pix_x[CHECK_SHIFT] ^ pix_y[CHECK_SHIFT]) ? 16'hFFFF : 16'h0000;
        MODE_SCROLL: color_d = palette(bar_sel(ex, BAR_W));
        default:     color_d = '0;
      endcase
`ifdef VGA_PAT_BORDER_EN
      if (pix_x == '0 || pix_x == H_LAST || pix_y == '0 || pix_y == V_LAST)
        color_d = 16'hFFFF;
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_data  <= '0;
      mode_q    <= MODE_VBAR;
      pending   <= MODE_VBAR;
      pend_flag <= 1'b0;
      offset    <= '0;
      frame_cnt <= '0;
    end else begin
      // The fb pixel itself is coloured with the old mode/offset because
      // color_d is built from the registered state before it updates.
      pix_data <= color_d;
      if (fb) begin
        frame_cnt <= frame_cnt + 8'd1;
        offset    <= off_nxt;
        pend_flag <= 1'b0;
        if (mode_vld) begin
          mode_q  <= mode_e'(mode_req);
          pending <= mode_e'(mode_req);
        end else if (pend_flag) begin
          mode_q  <= pending;
        end
      end else if (mode_vld) begin
        pending   <= mode_e'(mode_req);
        pend_flag <= 1'b1;
      end
    end
  end

  assign mode_cur = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen
//   Self-checking bench for vga_pattern_gen. Two instances share the inputs:
//   the default build and one with SCROLL_STEP=300 to exercise offset wrap.
//   Coordinates are driven directly, so a frame boundary is simply the
//   coordinate (H_VALID-1, V_VALID-1). Expected values come from a reference
//   model using plain division/modulo arithmetic.
module tb_vga_pattern_gen;

  localparam int H     = 640;
  localparam int V     = 480;
  localparam int BARS  = 8;
  localparam int CS    = 5;
  localparam int STEP  = 4;
  localparam int STEP2 = 300;
  localparam int BW    = H / BARS;
  localparam int BH    = V / BARS;

  logic        vga_clk;
  logic        sys_rst_n;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [1:0]  mode_req;
  logic        mode_vld;
  logic [15:0] pix_data;
  logic [1:0]  mode_cur;
  logic [7:0]  frame_cnt;
  logic [15:0] pix_data2;
  logic [1:0]  mode_cur2;
  logic [7:0]  frame_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_mode, m_pend, m_flag, m_off, m_off2, m_fc;

  logic [15:0] pal [8] = '{16'hF800, 16'hFC00, 16'hFFE0, 16'h07E0,
                           16'h07FF, 16'h001F, 16'hF81F, 16'hFFFF};

  vga_pattern_gen #(.H_VALID(H), .V_VALID(V), .BAR_NUM(BARS),
                    .CHECK_SHIFT(CS), .SCROLL_STEP(STEP)) u_dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .mode_req(mode_req), .mode_vld(mode_vld), .pix_data(pix_data),
    .mode_cur(mode_cur), .frame_cnt(frame_cnt));

  vga_pattern_gen #(.H_VALID(H), .V_VALID(V), .BAR_NUM(BARS),
                    .CHECK_SHIFT(CS), .SCROLL_STEP(STEP2)) u_dut_wrap (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .mode_req(mode_req), .mode_vld(mode_vld), .pix_data(pix_data2),
    .mode_cur(mode_cur2), .frame_cnt(frame_cnt2));

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_pix(input int x, input int y, input int mode, input int off);
    if (x >= H || y >= V) return 16'h0000;
`ifdef VGA_PAT_BORDER_EN
    if (x == 0 || x == H - 1 || y == 0 || y == V - 1) return 16'hFFFF;
`endif
    case (mode)
      0:       return pal[(x / BW) % 8];
      1:       return pal[(y / BH) % 8];
      2:       return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return pal[(((x + off) % H) / BW) % 8];
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_flag = 0; m_off = 0; m_off2 = 0; m_fc = 0;
  endtask

  // One pixel: drive, predict, clock, then compare just after the edge.
  task automatic step(input int x, input int y, input bit vld, input int req);
    logic [15:0] e1, e2;
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    mode_vld = vld;
    mode_req = 2'(req);
    e1 = ref_pix(x, y, m_mode, m_off);
    e2 = ref_pix(x, y, m_mode, m_off2);
    if (x == H - 1 && y == V - 1) begin
      m_fc   = (m_fc + 1) % 256;
      m_off  = (m_off + STEP) % H;
      m_off2 = (m_off2 + STEP2) % H;
      if (vld) begin m_mode = req; m_flag = 0; end
      else if (m_flag != 0) begin m_mode = m_pend; m_flag = 0; end
    end else if (vld) begin
      m_pend = req; m_flag = 1;
    end
    @(posedge vga_clk);
    #1;
    mode_vld = 1'b0;
    check_val("pix", 32'(pix_data), 32'(e1));
    check_val("pix_wrap", 32'(pix_data2), 32'(e2));
    check_val("mode_cur", 32'(mode_cur), 32'(m_mode));
    check_val("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    check_val("frame_cnt_wrap", 32'(frame_cnt2), 32'(m_fc));
  endtask

  task automatic frame_end(input bit vld, input int req);
    step(H - 1, V - 1, vld, req);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic apply_reset();
    pix_x = 10'd700; pix_y = 10'd0; mode_vld = 1'b0; mode_req = 2'd0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_val("rst_pix", 32'(pix_data), 32'h0);
    check_val("rst_mode", 32'(mode_cur), 32'h0);
    check_val("rst_fc", 32'(frame_cnt), 32'h0);
    check_val("rst_pix_wrap", 32'(pix_data2), 32'h0);
    model_reset();
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    pix_x = '0; pix_y = '0; mode_req = '0; mode_vld = 1'b0;
    model_reset();
    #3;
    check_val("por_pix", 32'(pix_data), 32'h0);
    check_val("por_mode", 32'(mode_cur), 32'h0);
    check_val("por_fc", 32'(frame_cnt), 32'h0);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;

    // vertical bars, default mode
    step(0, 0, 0, 0);
    step(79, 0, 0, 0);
    step(80, 0, 0, 0);
    step(639, 0, 0, 0);
    step(640, 0, 0, 0);
    check_val("lit_black_x640", 32'(pix_data), 32'h0000);
    step(79, 5, 0, 0);
    check_val("lit_vbar0", 32'(pix_data), 32'hF800);
    step(80, 5, 0, 0);
    check_val("lit_vbar1", 32'(pix_data), 32'hFC00);

    // request hbars mid-frame; frame keeps vbars until boundary
    step(10, 100, 1, 1);
    step(200, 101, 0, 0);
    step(5, 479, 0, 0);
    check_val("mode_held", 32'(mode_cur), 32'd0);
    frame_end(0, 0);
    check_val("mode_after_fb", 32'(mode_cur), 32'd1);
    step(5, 59, 0, 0);
    check_val("lit_hbar0", 32'(pix_data), 32'hF800);
    step(5, 60, 0, 0);
    check_val("lit_hbar1", 32'(pix_data), 32'hFC00);

    // request coincident with frame boundary -> checkerboard
    frame_end(1, 2);
    check_val("mode_direct", 32'(mode_cur), 32'd2);
    step(32, 1, 0, 0);
    check_val("lit_chk_a", 32'(pix_data), 32'hFFFF);
    step(32, 32, 0, 0);
    check_val("lit_chk_b", 32'(pix_data), 32'h0000);
    step(31, 63, 0, 0);
    check_val("lit_chk_c", 32'(pix_data), 32'hFFFF);
    // pend_flag must have been cleared: a plain boundary keeps mode 2
    frame_end(0, 0);
    check_val("mode_no_stale", 32'(mode_cur), 32'd2);

    // two requests in one frame, last wins
    step(3, 3, 1, 1);
    step(4, 3, 1, 3);
    frame_end(0, 0);
    check_val("mode_last_wins", 32'(mode_cur), 32'd3);

    // scroll: 20 frames from reset give offset 80 (and 300/600/260 for the wrap instance)
    apply_reset();
    frame_end(1, 3);
    step(40, 3, 0, 0);
    check_val("lit_wrap_300", 32'(pix_data2), 32'h07FF);
    frame_end(0, 0);
    step(40, 3, 0, 0);
    check_val("lit_wrap_600", 32'(pix_data2), 32'hF800);
    frame_end(0, 0);
    step(40, 3, 0, 0);
    check_val("lit_wrap_260", 32'(pix_data2), 32'h07E0);
    for (int f = 0; f < 17; f++) frame_end(0, 0);
    step(2, 3, 0, 0);
    check_val("lit_scroll_x2", 32'(pix_data), 32'hFC00);
    step(560, 3, 0, 0);
    check_val("lit_scroll_x560", 32'(pix_data), 32'hF800);

    // reset mid-frame in mode 3 with frame_cnt=7
    apply_reset();
    frame_end(1, 3);
    for (int f = 0; f < 6; f++) frame_end(0, 0);
    step(100, 200, 0, 0);
    check_val("fc_before_rst", 32'(frame_cnt), 32'd7);
    apply_reset();
    step(80, 5, 0, 0);
    check_val("lit_post_rst", 32'(pix_data), 32'hFC00);
`ifdef VGA_PAT_BORDER_EN
    step(0, 10, 0, 0);
    check_val("lit_border", 32'(pix_data), 32'hFFFF);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)
        frame_end($urandom_range(0, 3) == 0, $urandom_range(0, 3));
      else if (r == 1)
        step($urandom_range(0, 1) ? H - 1 : $urandom_range(0, 1023), V - 1,
             $urandom_range(0, 7) == 0, $urandom_range(0, 3));
      else
        step($urandom_range(0, 700), $urandom_range(0, 520),
             $urandom_range(0, 7) == 0, $urandom_range(0, 3));
      if (i == 1500) apply_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
